// File: rtl/ans_decoder_pkg.sv
// Shared widths, table constants and FSM encoding for the rANS decoder.
// The width macros are also used by ans_encoder, so each is guarded.
`ifndef SYM_WIDTH
`define SYM_WIDTH 8
`endif
`ifndef CNT_WIDTH
`define CNT_WIDTH 8
`endif
`ifndef STATE_WIDTH
`define STATE_WIDTH 16
`endif

package ans_decoder_pkg;

  localparam int SYM_W          = `SYM_WIDTH;
  localparam int CNT_W          = `CNT_WIDTH;
  localparam int STATE_W        = `STATE_WIDTH;
  localparam int CUM_W          = SYM_W + CNT_W;
  localparam int SCALE_BITS_DEF = 8;
  localparam int NUM_SYMS_DEF   = 256;

  // Chunks needed to fill the state register from empty.
  localparam int LOAD_CHUNKS = STATE_W / SYM_W;
  localparam int LOAD_CNT_W  = $clog2(LOAD_CHUNKS + 1);

  // Renormalisation lower bound L.
  localparam logic [STATE_W-1:0] RENORM_L = STATE_W'(1) << (STATE_W - SYM_W);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_SEARCH,
    ST_EMIT,
    ST_RENORM,
    ST_HALT
  } dec_state_e;

endpackage

// File: rtl/ans_decoder_if.sv
// Chunk input, symbol output and frequency-table lookup of ans_decoder.
// The decoder is the slave; the environment (source, sink, table) is the master.
interface ans_decoder_if;
  import ans_decoder_pkg::*;

  logic [SYM_W-1:0] in;
  logic             in_vld;
  logic             in_rdy;
  logic [SYM_W-1:0] out;
  logic             out_vld;
  logic             out_rdy;
  logic [SYM_W-1:0] tbl_idx;
  logic [CNT_W-1:0] tbl_count;
  logic [CUM_W-1:0] tbl_cumulative;

  modport master (
    output in, in_vld, out_rdy, tbl_count, tbl_cumulative,
    input  in_rdy, out, out_vld, tbl_idx
  );

  modport slave (
    input  in, in_vld, out_rdy, tbl_count, tbl_cumulative,
    output in_rdy, out, out_vld, tbl_idx
  );

endinterface

// File: rtl/ans_state_update.sv
// Combinational rANS state step: slot extraction, x' = count*(x>>S) + slot - cum,
// and the renormalisation test on the current state.
module ans_state_update
  import ans_decoder_pkg::*;
#(
  parameter int SCALE_BITS = SCALE_BITS_DEF
) (
  input  logic [STATE_W-1:0]    x,
  input  logic [CNT_W-1:0]      count,
  input  logic [CUM_W-1:0]      cumulative,
  output logic [SCALE_BITS-1:0] slot,
  output logic [STATE_W-1:0]    x_next,
  output logic                  renorm
);

  assign slot   = x[SCALE_BITS-1:0];
  // Wide intermediate, then truncate to the state width as the encoder does.
  assign x_next = STATE_W'(32'(count) * 32'(x >> SCALE_BITS)
                           + 32'(slot) - 32'(cumulative));
  assign renorm = (x < RENORM_L);

endmodule

// File: rtl/ans_decoder.sv
// rANS decoder: loads state from the chunk stream, then searches the symbol
// table linearly, emits the symbol, updates the state and renormalises.
module ans_decoder
  import ans_decoder_pkg::*;
#(
  parameter int SCALE_BITS = SCALE_BITS_DEF,
  parameter int NUM_SYMS   = NUM_SYMS_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               restart,
  ans_decoder_if.slave       bus,
  output logic               err
);

  dec_state_e            state_q, state_d;
  logic [STATE_W-1:0]    x_q, x_d;
  logic [LOAD_CNT_W-1:0] load_q, load_d;
  logic [SYM_W-1:0]      idx_q, idx_d;
  logic                  in_rdy_q, in_rdy_d;
  logic [SYM_W-1:0]      out_q, out_d;
  logic                  out_vld_q, out_vld_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [CUM_W-1:0]      cum_q, cum_d;

  logic [SCALE_BITS-1:0] slot;
  logic [STATE_W-1:0]    x_upd;
  logic                  renorm;
  logic [STATE_W-1:0]    x_shift;
  logic [CUM_W-1:0]      slot_w;
  logic                  hit;
  logic                  in_xfer;
  logic                  out_xfer;

  ans_state_update #(.SCALE_BITS(SCALE_BITS)) u_update (
    .x          (x_q),
    .count      (cnt_q),
    .cumulative (cum_q),
    .slot       (slot),
    .x_next     (x_upd),
    .renorm     (renorm)
  );

  assign x_shift  = {x_q[STATE_W-SYM_W-1:0], bus.in};
  assign in_xfer  = bus.in_vld & in_rdy_q;
  assign out_xfer = out_vld_q & bus.out_rdy;

  // A zero-count entry can never own a slot, whatever its cumulative says.
  assign slot_w = CUM_W'(slot);
  assign hit    = (bus.tbl_count != '0)
               && (slot_w >= bus.tbl_cumulative)
               && (slot_w <  bus.tbl_cumulative + CUM_W'(bus.tbl_count));

  always_comb begin
    // NOTE: every target gets its held value first so no path can infer a latch.
    state_d   = state_q;
    x_d       = x_q;
    load_d    = load_q;
    idx_d     = idx_q;
    in_rdy_d  = in_rdy_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    cum_d     = cum_q;

    unique case (state_q)
      ST_LOAD: begin
        if (in_xfer) begin
          x_d    = x_shift;
          load_d = load_q + 1'b1;
          if (load_q == LOAD_CNT_W'(LOAD_CHUNKS - 1)) begin
            in_rdy_d = 1'b0;
            idx_d    = '0;
            state_d  = ST_SEARCH;
          end
        end
      end

      ST_SEARCH: begin
        if (hit) begin
          out_d     = idx_q;
          out_vld_d = 1'b1;
          cnt_d     = bus.tbl_count;
          cum_d     = bus.tbl_cumulative;
          state_d   = ST_EMIT;
        end else if (idx_q == SYM_W'(NUM_SYMS - 1)) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      ST_EMIT: begin
        if (out_xfer) begin
          out_vld_d = 1'b0;
          x_d       = x_upd;
          state_d   = ST_RENORM;
        end
      end

      ST_RENORM: begin
        // Drop in_rdy on the accepting edge itself when the shifted state is
        // already large enough, so no surplus chunk is ever taken.
        if (in_rdy_q) begin
          if (in_xfer) begin
            x_d      = x_shift;
            in_rdy_d = (x_shift < RENORM_L);
          end
        end else if (!renorm) begin
          idx_d   = '0;
          state_d = ST_SEARCH;
        end else begin
          in_rdy_d = 1'b1;
        end
      end

      ST_HALT: begin
        in_rdy_d  = 1'b0;
        out_vld_d = 1'b0;
      end

      default: state_d = ST_LOAD;
    endcase

    if (restart) begin
      x_d       = '0;
      load_d    = '0;
      out_vld_d = 1'b0;
      in_rdy_d  = 1'b1;
      err_d     = 1'b0;
      state_d   = ST_LOAD;
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD;
      x_q       <= '0;
      load_q    <= '0;
      idx_q     <= '0;
      in_rdy_q  <= 1'b1;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      cum_q     <= '0;
    end else if (ena) begin
      state_q   <= state_d;
      x_q       <= x_d;
      load_q    <= load_d;
      idx_q     <= idx_d;
      in_rdy_q  <= in_rdy_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      cum_q     <= cum_d;
    end
  end

  assign bus.in_rdy  = in_rdy_q;
  assign bus.out     = out_q;
  assign bus.out_vld = out_vld_q;
  assign bus.tbl_idx = idx_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ans_decoder.sv
// Self-checking bench for ans_decoder: directed scenarios plus randomized
// tables/chunk streams compared with an arithmetic rANS reference model.
module tb_ans_decoder;
  import ans_decoder_pkg::*;

  localparam int M = 1 << SCALE_BITS_DEF;
  localparam int L = 1 << (STATE_W - SYM_W);

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic restart;
  logic err;

  ans_decoder_if bus ();

  ans_decoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .restart (restart),
    .bus     (bus),
    .err     (err)
  );

  always #5 clk = ~clk;

  int tcnt [NUM_SYMS_DEF];
  int tcum [NUM_SYMS_DEF];
  assign bus.tbl_count      = CNT_W'(tcnt[bus.tbl_idx]);
  assign bus.tbl_cumulative = CUM_W'(tcum[bus.tbl_idx]);

  int checks = 0;
  int errors = 0;

  logic [7:0] src[$];
  logic [7:0] feed[$];
  int got_sym[$], got_x[$], got_ex[$];
  int exp_sym[$], exp_x[$], exp_ex[$];
  int load_cyc, vld_cyc, last_n_in, rdy_after_load, frozen_bad;
  int hs_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    ena     = 1'b1;
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < NUM_SYMS_DEF; i++) begin
      tcnt[i] = 0;
      tcum[i] = 0;
    end
  endtask

  task automatic set_tbl1();
    clear_tbl();
    tcnt[0] = 128; tcum[0] = 0;
    tcnt[1] = 128; tcum[1] = 128;
  endtask

  task automatic set_tbl2();
    clear_tbl();
    tcnt[0] = 255; tcum[0] = 0;
    tcnt[1] = 1;   tcum[1] = 255;
  endtask

  // Random partition of [0,M) over the table; entry 0 is never empty so the
  // last entry's remainder always fits the count width.
  task automatic set_tbl_rand();
    int cum, c;
    cum = 0;
    for (int i = 0; i < NUM_SYMS_DEF; i++) begin
      if (i == NUM_SYMS_DEF - 1) c = M - cum;
      else if (i == 0)           c = int'($urandom_range(1, 40));
      else                       c = int'($urandom_range(0, 40));
      if (c > M - cum) c = M - cum;
      tcnt[i] = c;
      tcum[i] = cum;
      cum += c;
    end
  endtask

  // Reference: rANS decode straight from the arithmetic definition.
  task automatic model_run(input int nsym);
    logic [7:0] q[$];
    int x, slot, s;
    q = src;
    x = 0;
    exp_sym.delete(); exp_x.delete(); exp_ex.delete();
    for (int i = 0; i < LOAD_CHUNKS; i++) x = x * 256 + int'(q.pop_front());
    for (int n = 0; n < nsym; n++) begin
      slot = x % M;
      s = -1;
      for (int i = 0; i < NUM_SYMS_DEF; i++)
        if (s < 0 && tcnt[i] > 0 && tcum[i] <= slot && slot < tcum[i] + tcnt[i]) s = i;
      exp_ex.push_back(x);
      exp_sym.push_back(s);
      x = (tcnt[s] * (x / M) + slot - tcum[s]) % 65536;
      exp_x.push_back(x);
      while (x < L && q.size() > 0) x = x * 256 + int'(q.pop_front());
    end
  endtask

  // Drives src into the DUT and collects nsym symbols, with optional random
  // stalls on both sides and optional ena toggling.
  task automatic decode(input int nsym, input bit stall, input bit ena_tog);
    int cyc, n_in;
    bit xi, xo, prev_vld;
    logic s_rdy, s_vld;
    logic [7:0] s_out, s_idx;
    logic [15:0] s_x;
    feed = src;
    got_sym.delete(); got_x.delete(); got_ex.delete();
    cyc = 0; n_in = 0; load_cyc = -1; vld_cyc = -1;
    rdy_after_load = 0; frozen_bad = 0;
    prev_vld = bus.out_vld;
    while (got_sym.size() < nsym && cyc < 3000) begin
      ena         = ena_tog ? (cyc % 2 == 0) : 1'b1;
      bus.in_vld  = (feed.size() > 0) && (!stall || $urandom_range(0, 2) != 0);
      bus.in      = (feed.size() > 0) ? feed[0] : 8'h00;
      bus.out_rdy = !stall || ($urandom_range(0, 1) == 1);
      xi = ena && bus.in_vld && bus.in_rdy;
      xo = ena && bus.out_vld && bus.out_rdy;
      if (bus.in_rdy && bus.out_vld) hs_bad++;
      s_rdy = bus.in_rdy; s_vld = bus.out_vld; s_out = bus.out;
      s_idx = bus.tbl_idx; s_x = dut.x_q;
      if (xo) got_sym.push_back(int'(bus.out));
      step();
      cyc++;
      if (!ena && (s_rdy !== bus.in_rdy || s_vld !== bus.out_vld || s_out !== bus.out
                   || s_idx !== bus.tbl_idx || s_x !== dut.x_q)) frozen_bad++;
      if (xi) begin
        void'(feed.pop_front());
        n_in++;
        if (n_in == LOAD_CHUNKS) load_cyc = cyc;
      end
      if (load_cyc >= 0 && bus.in_rdy) rdy_after_load++;
      if (xo) got_x.push_back(int'(dut.x_q));
      if (bus.out_vld && !prev_vld) begin
        got_ex.push_back(int'(dut.x_q));
        if (vld_cyc < 0) vld_cyc = cyc;
      end
      prev_vld = bus.out_vld;
    end
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b0;
    ena         = 1'b1;
    last_n_in   = n_in;
    check("decode_done", got_sym.size(), nsym);
  endtask

  task automatic wait_vld(input string tag);
    int n;
    n = 0;
    while (!bus.out_vld && n < 600) begin
      step();
      n++;
    end
    check(tag, 32'(bus.out_vld), 1);
  endtask

  task automatic load2(input logic [7:0] a, input logic [7:0] b);
    bus.in_vld = 1'b1;
    bus.in = a;
    step();
    bus.in = b;
    step();
    bus.in_vld = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bp_bad, n;
    logic [7:0] hold_out;

    rst_n = 1'b0; ena = 1'b1; restart = 1'b0;
    bus.in = 8'h00; bus.in_vld = 1'b0; bus.out_rdy = 1'b0;
    set_tbl1();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    // Reset values
    check("rst_in_rdy", 32'(bus.in_rdy), 1);
    check("rst_out_vld", 32'(bus.out_vld), 0);
    check("rst_err", 32'(err), 0);
    check("rst_tbl_idx", 32'(bus.tbl_idx), 0);
    check("rst_out", 32'(bus.out), 0);
    check("rst_x", 32'(dut.x_q), 0);

    // Two-symbol table, no renormalisation
    src = '{8'h12, 8'h34};
    decode(3, 1'b0, 1'b0);
    check("t1_sym0", got_sym[0], 0);
    check("t1_sym1", got_sym[1], 0);
    check("t1_sym2", got_sym[2], 1);
    check("t1_x0", got_x[0], 'h0934);
    check("t1_x1", got_x[1], 'h04B4);
    check("t1_x2", got_x[2], 'h0234);
    check("t1_search_cycles", vld_cyc - load_cyc, 1);
    check("t1_chunks", last_n_in, 2);
    check("t1_no_rdy_after_load", rdy_after_load, 0);

    // Skewed table with one renormalisation read
    do_restart();
    set_tbl2();
    src = '{8'h12, 8'hFF, 8'hAB};
    decode(2, 1'b0, 1'b0);
    check("t2_sym0", got_sym[0], 1);
    check("t2_sym1", got_sym[1], 0);
    check("t2_search_cycles", vld_cyc - load_cyc, 2);
    check("t2_x_after_update", got_x[0], 'h0012);
    check("t2_x_after_renorm", got_ex[1], 'h12AB);
    check("t2_chunks", last_n_in, 3);

    // Backpressure in EMIT
    do_restart();
    set_tbl1();
    load2(8'h12, 8'h34);
    wait_vld("bp_vld");
    hold_out = bus.out;
    bp_bad = 0;
    repeat (5) begin
      step();
      if (bus.out !== hold_out || dut.x_q !== 16'h1234 || bus.in_rdy || !bus.out_vld) bp_bad++;
    end
    check("bp_stable", bp_bad, 0);
    bus.out_rdy = 1'b1;
    check("bp_x_hold", 32'(dut.x_q), 'h1234);
    step();
    bus.out_rdy = 1'b0;
    check("bp_x_update", 32'(dut.x_q), 'h0934);
    check("bp_vld_drop", 32'(bus.out_vld), 0);

    // All-zero table: search runs off the end
    do_restart();
    clear_tbl();
    load2(8'h55, 8'h66);
    check("bad_rdy_after_load", 32'(bus.in_rdy), 0);
    n = 0;
    while (!err && n < 400) begin
      step();
      n++;
    end
    check("bad_err_cycles", n, NUM_SYMS_DEF);
    repeat (3) step();
    check("bad_err_sticky", 32'(err), 1);
    check("halt_in_rdy", 32'(bus.in_rdy), 0);
    check("halt_out_vld", 32'(bus.out_vld), 0);
    do_restart();
    check("restart_err", 32'(err), 0);
    check("restart_in_rdy", 32'(bus.in_rdy), 1);

    // Async reset after a partial load
    set_tbl1();
    bus.in_vld = 1'b1;
    bus.in = 8'h12;
    step();
    bus.in_vld = 1'b0;
    check("partial_x", 32'(dut.x_q), 'h0012);
    rst_n = 1'b0;
    #1;
    check("async_rst_x", 32'(dut.x_q), 0);
    check("async_rst_rdy", 32'(bus.in_rdy), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    src = '{8'h12, 8'h34};
    decode(3, 1'b0, 1'b0);
    check("rl_sym0", got_sym[0], 0);
    check("rl_sym1", got_sym[1], 0);
    check("rl_sym2", got_sym[2], 1);

    // restart drops a pending symbol
    wait_vld("emit_pending");
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart_emit_vld", 32'(bus.out_vld), 0);
    check("restart_emit_rdy", 32'(bus.in_rdy), 1);

    // Clock enable toggled every other cycle
    src = '{8'h12, 8'h34};
    decode(3, 1'b0, 1'b1);
    check("ena_sym0", got_sym[0], 0);
    check("ena_sym1", got_sym[1], 0);
    check("ena_sym2", got_sym[2], 1);
    check("ena_x2", got_x[2], 'h0234);
    check("ena_frozen", frozen_bad, 0);

    // Random tables and streams against the reference model
    for (int r = 0; r < 4; r++) begin
      do_restart();
      set_tbl_rand();
      src.delete();
      for (int i = 0; i < 40; i++) src.push_back(8'($urandom_range(0, 255)));
      model_run(12);
      decode(12, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) begin
        if (i < got_sym.size()) begin
          check($sformatf("rnd%0d_sym%0d", r, i), got_sym[i], exp_sym[i]);
          check($sformatf("rnd%0d_x%0d", r, i), got_x[i], exp_x[i]);
          check($sformatf("rnd%0d_xs%0d", r, i), got_ex[i], exp_ex[i]);
        end
      end
    end

    check("in_rdy_out_vld_exclusive", hs_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ans_decoder.md
Name: ans_decoder

Overview:
- rANS decoder: the receive-side counterpart to ans_encoder; turns an ordered chunk stream back into symbols.
- Loads its state from the chunk stream, then repeats: find the symbol, emit it, update the state, renormalise.
- Symbol statistics come from an external table addressed by the decoder, using the same count/cumulative convention the encoder uses.
- Upstream logic delivers chunks in decode order, i.e. the reverse of encoder emission order.

Parameters:
- SCALE_BITS, 8, total count M = 1<<SCALE_BITS; tbl_cumulative+tbl_count <= M.
- NUM_SYMS, 256, table entries searched, indices 0..NUM_SYMS-1.
- Widths come from the shared defines `SYM_WIDTH (8), `CNT_WIDTH (8) and `STATE_WIDTH (16).
- Renorm lower bound L = 1<<(`STATE_WIDTH-`SYM_WIDTH).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  clock enable; when 0 all registers hold
- restart  in  1  synchronous; forces LOAD next cycle
- in  in  `SYM_WIDTH  compressed chunk
- in_vld  in  1  chunk valid
- in_rdy  out  1  decoder accepts chunk
- tbl_idx  out  `SYM_WIDTH  table index under test
- tbl_count  in  `CNT_WIDTH  count of entry tbl_idx (combinational, same cycle)
- tbl_cumulative  in  `SYM_WIDTH+`CNT_WIDTH  cumulative of entry tbl_idx
- out  out  `SYM_WIDTH  decoded symbol
- out_vld  out  1  symbol valid
- out_rdy  in  1  sink accepts symbol
- err  out  1  sticky: table search failed

Behaviour:
- Reset values: state=LOAD, x=0, load counter=0, tbl_idx=0, in_rdy=1, out=0, out_vld=0, err=0.
- Transfers: a chunk transfers on in_vld&in_rdy with ena; a symbol transfers on out_vld&out_rdy with ena.
- LOAD:
  - in_rdy=1; each transfer does x <= (x<<`SYM_WIDTH)|in.
  - After `STATE_WIDTH/`SYM_WIDTH transfers (2 by default), in_rdy<=0, tbl_idx<=0, go SEARCH.
- SEARCH:
  - slot = x[SCALE_BITS-1:0].
  - Each cycle tests tbl_idx: tbl_cumulative <= slot < tbl_cumulative+tbl_count.
  - Hit: out<=tbl_idx, out_vld<=1, latch count/cumulative, go EMIT.
  - Miss: tbl_idx+1.
  - Miss at NUM_SYMS-1: err<=1, go HALT.
  - A hit on index i takes i+1 cycles.
  - Comparisons are done at `SYM_WIDTH+`CNT_WIDTH width; count=0 never hits.
- EMIT:
  - Hold out/out_vld until out_rdy.
  - On transfer: out_vld<=0, x <= count*(x>>SCALE_BITS) + slot - cumulative, truncated to `STATE_WIDTH, go RENORM.
- RENORM:
  - If x >= L: tbl_idx<=0, go SEARCH, in_rdy stays 0.
  - Else in_rdy=1; each transfer does x <= (x<<`SYM_WIDTH)|in, then re-check.
  - Loops until x >= L. With count>=1, at most 2 transfers.
- HALT: in_rdy=0, out_vld=0; leave only via restart or reset.
- restart:
  - Wins over every other event in the same cycle.
  - x<=0, load counter<=0, out_vld<=0, in_rdy<=1, err<=0, go LOAD.
  - A symbol pending in EMIT is dropped.
- Handshake rules:
  - in_rdy and out_vld are registered and never both 1.
  - out is stable while out_vld=1.
- ena=0: all state frozen, including mid-handshake; a transfer requires ena=1.
- rst_n assert mid-operation: immediate return to reset values; a partial load is discarded.

Decomposition:
- Shared package/defines: `SYM_WIDTH, `CNT_WIDTH and `STATE_WIDTH (already shared with ans_encoder), plus state encodings LOAD/SEARCH/EMIT/RENORM/HALT.
- Sub-module ans_state_update (combinational): inputs x, count, cumulative; outputs slot, next x, renorm-needed flag. It is reusable by a future table-less encoder check.

Test Plan:
- Table {0:cnt128,cum0; 1:cnt128,cum128}; chunks 0x12,0x34 -> symbols 0,0,1 with x = 0x0934, 0x04B4, 0x0234; in_rdy stays 0 after LOAD.
- Table {0:cnt255,cum0; 1:cnt1,cum255}; chunks 0x12,0xFF,0xAB -> symbol 1 after 2 SEARCH cycles; x=0x0012, one RENORM read gives x=0x12AB; next symbol 0.
- Backpressure: out_rdy=0 for 5 cycles during EMIT -> out stable, x unchanged, no in_rdy; update occurs the cycle after out_rdy=1.
- Bad table (all counts 0) -> err=1 after NUM_SYMS SEARCH cycles, HALT; restart -> err=0, in_rdy=1.
- rst_n low after the first LOAD chunk, then reload 0x12,0x34 -> same output as test 1; restart asserted during EMIT -> out_vld=0 next cycle.
- ena toggled every other cycle during test 1 -> identical symbol sequence; no transfer occurs while ena=0.
